ps2_key_tracker: RTL and testbench

- Parametrised PS/2 keyboard receiver (device-to-host only) with a per-key state tracker.
- Filters PS2_CLK, frames and validates 11-bit packets (start/odd-parity/stop, timeout), and decodes E0/F0 prefixes into make/break events.
- Maintains held and latched bitmaps for the team's 33-key set; each key is individually toggle- or momentary-mode.
- Sits between the board PS/2 pins and game/UI logic; drives HEX0/HEX1 with the last scancode.

---
 rtl/ps2_key_tracker.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_ps2_key_tracker.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard receiver (device-to-host) with a per-key held/latched tracker.
// Raw pins are synchronised and glitch-filtered, 11-bit frames are validated,
// E0/F0 prefixes are folded into make/break events, and a 33-key bitmap pair
// is maintained for game/UI logic. HEX0/HEX1 show the last scancode.
module ps2_key_tracker #(
    parameter int          FILTER_LEN     = 8,
    parameter int          TIMEOUT_CYCLES = 100000,
    parameter logic [32:0] TOGGLE_MASK    = 33'h07FFFFFFF
) (
    input  logic        CLOCK_50,
    input  logic        Resetn,
    input  logic        PS2_CLK,
    input  logic        PS2_DAT,
    output logic [7:0]  scan_code,
    output logic        scan_valid,
    output logic        scan_break,
    output logic        scan_ext,
    output logic        frame_err,
    output logic [32:0] key_held,
    output logic [32:0] key_state,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1
);

    localparam int FCW = $clog2(FILTER_LEN);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BRK = 8'hF0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Input conditioning
    logic           clk_meta, clk_sync;
    logic           dat_meta, dat_sync;
    logic           filt_level;
    logic [FCW-1:0] filt_cnt;
    logic           fall_edge;

    // Framing
    state_t         state_q, state_d;
    logic [2:0]     bit_cnt;
    logic [7:0]     shift_q;
    logic           par_q;
    logic [TCW-1:0] to_cnt;
    logic           shift_en, par_en, byte_ok, stop_err, timeout;

    // Event decoding
    logic           ext_flag, brk_flag;
    logic           map_hit;
    logic [5:0]     map_idx;

    // Two-flop synchronisers; pins idle high, so they reset to 1.
    // NOTE: clocked state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbours, exactly like the hardware.
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
        end else begin
            clk_meta <= PS2_CLK;
            clk_sync <= clk_meta;
            dat_meta <= PS2_DAT;
            dat_sync <= dat_meta;
        end
    end

    // Glitch filter: the level flips only after FILTER_LEN consecutive samples
    // disagreeing with it; a falling flip emits a one-cycle fall_edge.
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            filt_level <= 1'b1;
            filt_cnt   <= '0;
            fall_edge  <= 1'b0;
        end else begin
            fall_edge <= 1'b0;
            if (clk_sync == filt_level) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
                filt_level <= clk_sync;
                filt_cnt   <= '0;
                fall_edge  <= ~clk_sync;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    // Frame FSM state register.
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Frame FSM next-state and per-edge control strobes.
    // NOTE: every always_comb output gets a default first, so no path through
    // the case can leave a value unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        shift_en = 1'b0;
        par_en   = 1'b0;
        byte_ok  = 1'b0;
        stop_err = 1'b0;
        timeout  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (fall_edge && !dat_sync) state_d = S_DATA;
            end
            S_DATA: begin
                if (fall_edge) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) state_d = S_PARITY;
                end
            end
            S_PARITY: begin
                if (fall_edge) begin
                    par_en  = 1'b1;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (fall_edge) begin
                    // Odd parity: data plus parity bit must hold an odd count of ones.
                    if (dat_sync && (^{shift_q, par_q})) byte_ok  = 1'b1;
                    else                                  stop_err = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // to_cnt counts cycles since the last edge; abort on the edge where it
        // would reach TIMEOUT_CYCLES.
        if (state_q != S_IDLE && !fall_edge && to_cnt == TCW'(TIMEOUT_CYCLES - 1)) begin
            timeout = 1'b1;
            state_d = S_IDLE;
        end
    end

    // Frame datapath: bit counter, LSB-first shifter, parity bit, timeout counter.
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            bit_cnt <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            to_cnt  <= '0;
        end else begin
            if (state_q == S_IDLE) bit_cnt <= '0;
            else if (shift_en)     bit_cnt <= bit_cnt + 1'b1;

            if (shift_en) shift_q <= {dat_sync, shift_q[7:1]};
            if (par_en)   par_q   <= dat_sync;

            if (fall_edge)              to_cnt <= TCW'(1);
            else if (state_q != S_IDLE) to_cnt <= to_cnt + 1'b1;
            else                        to_cnt <= '0;
        end
    end

    // Map a scancode onto the 33-key index space.
    always_comb begin
        map_hit = 1'b1;
        map_idx = 6'd0;
        case (shift_q)
            8'h1C: map_idx = 6'd0;   // A
            8'h32: map_idx = 6'd1;   // B
            8'h21: map_idx = 6'd2;   // C
            8'h23: map_idx = 6'd3;   // D
            8'h24: map_idx = 6'd4;   // E
            8'h2B: map_idx = 6'd5;   // F
            8'h34: map_idx = 6'd6;   // G
            8'h33: map_idx = 6'd7;   // H
            8'h43: map_idx = 6'd8;   // I
            8'h3B: map_idx = 6'd9;   // J
            8'h42: map_idx = 6'd10;  // K
            8'h4B: map_idx = 6'd11;  // L
            8'h3A: map_idx = 6'd12;  // M
            8'h31: map_idx = 6'd13;  // N
            8'h44: map_idx = 6'd14;  // O
            8'h4D: map_idx = 6'd15;  // P
            8'h15: map_idx = 6'd16;  // Q
            8'h2D: map_idx = 6'd17;  // R
            8'h1B: map_idx = 6'd18;  // S
            8'h2C: map_idx = 6'd19;  // T
            8'h3C: map_idx = 6'd20;  // U
            8'h2A: map_idx = 6'd21;  // V
            8'h1D: map_idx = 6'd22;  // W
            8'h22: map_idx = 6'd23;  // X
            8'h35: map_idx = 6'd24;  // Y
            8'h1A: map_idx = 6'd25;  // Z
            8'h0C: map_idx = 6'd26;  // F4
            8'h04: map_idx = 6'd27;  // F3
            8'h29: map_idx = 6'd28;  // Space
            8'h5A: map_idx = 6'd29;  // Enter
            8'h66: map_idx = 6'd30;  // Backspace
            8'h12: map_idx = 6'd31;  // Left Shift
            8'h14: map_idx = 6'd32;  // Left Ctrl
            default: map_hit = 1'b0;
        endcase
    end

    // Event decode and bitmap update, one cycle after the stop-bit edge, so
    // the bitmaps change on the same edge that raises scan_valid.
    // NOTE: the key bitmaps are plain registers, not a RAM, so they are reset
    // along with everything else; a real memory array would be left unreset.
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;
            scan_code  <= '0;
            scan_break <= 1'b0;
            scan_ext   <= 1'b0;
            ext_flag   <= 1'b0;
            brk_flag   <= 1'b0;
            key_held   <= '0;
            key_state  <= '0;
        end else begin
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (stop_err || timeout) begin
                // A broken frame could have been a prefix; drop any pending ones.
                frame_err <= 1'b1;
                ext_flag  <= 1'b0;
                brk_flag  <= 1'b0;
            end else if (byte_ok) begin
                if (shift_q == CODE_EXT) begin
                    ext_flag <= 1'b1;
                end else if (shift_q == CODE_BRK) begin
                    brk_flag <= 1'b1;
                end else begin
                    scan_valid <= 1'b1;
                    scan_code  <= shift_q;
                    scan_break <= brk_flag;
                    scan_ext   <= ext_flag;
                    ext_flag   <= 1'b0;
                    brk_flag   <= 1'b0;
                    if (!ext_flag && map_hit) begin
                        if (!brk_flag) begin
                            // Only the first make of a press toggles; typematic repeats do not.
                            if (!TOGGLE_MASK[map_idx])    key_state[map_idx] <= 1'b1;
                            else if (!key_held[map_idx])  key_state[map_idx] <= ~key_state[map_idx];
                            key_held[map_idx] <= 1'b1;
                        end else if (key_held[map_idx]) begin
                            key_held[map_idx] <= 1'b0;
                            if (!TOGGLE_MASK[map_idx]) key_state[map_idx] <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    // Active-low seven-segment pattern, segment order gfedcba.
    function automatic logic [6:0] hex_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    assign HEX0 = hex_seg(scan_code[3:0]);
    assign HEX1 = hex_seg(scan_code[7:4]);

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker: frames are bit-banged on the pins and
// every expectation is a hand-computed constant.
module tb_ps2_key_tracker;

    localparam int F  = 8;    // FILTER_LEN
    localparam int T  = 200;  // TIMEOUT_CYCLES (shortened to keep the run small)
    localparam int HB = 20;   // half PS/2 bit period in CLOCK_50 cycles

    logic        CLOCK_50 = 1'b0;
    logic        Resetn   = 1'b0;
    logic        PS2_CLK  = 1'b1;
    logic        PS2_DAT  = 1'b1;
    logic [7:0]  scan_code;
    logic        scan_valid, scan_break, scan_ext, frame_err;
    logic [32:0] key_held, key_state;
    logic [6:0]  HEX0, HEX1;

    ps2_key_tracker #(
        .FILTER_LEN    (F),
        .TIMEOUT_CYCLES(T),
        .TOGGLE_MASK   (33'h07FFFFFFF)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .Resetn    (Resetn),
        .PS2_CLK   (PS2_CLK),
        .PS2_DAT   (PS2_DAT),
        .scan_code (scan_code),
        .scan_valid(scan_valid),
        .scan_break(scan_break),
        .scan_ext  (scan_ext),
        .frame_err (frame_err),
        .key_held  (key_held),
        .key_state (key_state),
        .HEX0      (HEX0),
        .HEX1      (HEX1)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int n_checks = 0;
    int n_pass   = 0;

    // Monitor state, sampled on the falling clock edge.
    int          cyc = 0;
    int          n_valid = 0;
    int          n_err = 0;
    int          valid_cyc = 0;
    logic [7:0]  last_code = '0;
    logic        last_brk = 1'b0;
    logic        last_ext = 1'b0;
    logic [32:0] held_at_valid = '0;
    logic [32:0] state_at_valid = '0;
    int          stop_fall_cyc = 0;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // Record every pulse and the bitmaps visible alongside scan_valid.
    always @(negedge CLOCK_50) begin
        if (scan_valid) begin
            n_valid        <= n_valid + 1;
            valid_cyc      <= cyc;
            last_code      <= scan_code;
            last_brk       <= scan_break;
            last_ext       <= scan_ext;
            held_at_valid  <= key_held;
            state_at_valid <= key_state;
        end
        if (frame_err) n_err <= n_err + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    // One 11-bit frame: start, data LSB-first, odd parity, stop.
    task automatic send_frame(input logic [7:0] b, input bit bad_par = 1'b0, input bit bad_stop = 1'b0);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            PS2_DAT = bits[i];
            wait_cycles(HB);
            PS2_CLK = 1'b0;
            if (i == 10) stop_fall_cyc = cyc;
            wait_cycles(HB);
            PS2_CLK = 1'b1;
        end
        PS2_DAT = 1'b1;
        wait_cycles(2 * HB);
    endtask

    // First n bits of a frame, leaving the clock low after the last falling edge.
    task automatic send_partial(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            PS2_DAT = bits[i];
            wait_cycles(HB);
            PS2_CLK = 1'b0;
            if (i != n - 1) begin
                wait_cycles(HB);
                PS2_CLK = 1'b1;
            end
        end
    endtask

    initial begin
        int v0, e0, first_k;

        // Reset values.
        wait_cycles(5);
        check("rst_valid", scan_valid, 1'b0);
        check("rst_err",   frame_err, 1'b0);
        check("rst_code",  scan_code, 8'h00);
        check("rst_held",  key_held, 33'h0);
        check("rst_state", key_state, 33'h0);
        check("rst_hex0",  HEX0, 7'b1000000);
        check("rst_hex1",  HEX1, 7'b1000000);
        Resetn = 1'b1;
        wait_cycles(5);

        // Single make of A (1C).
        v0 = n_valid; e0 = n_err;
        send_frame(8'h1C);
        check("a_nvalid",  n_valid - v0, 1);
        check("a_nerr",    n_err - e0, 0);
        check("a_code",    last_code, 8'h1C);
        check("a_brk",     last_brk, 1'b0);
        check("a_ext",     last_ext, 1'b0);
        check("a_latency", valid_cyc - stop_fall_cyc, F + 3);
        check("a_held_at_valid",  held_at_valid[0], 1'b1);
        check("a_state_at_valid", state_at_valid[0], 1'b1);
        check("a_held",    key_held, 33'h1);
        check("a_state",   key_state, 33'h1);
        check("a_hex1",    HEX1, 7'b1111001);
        check("a_hex0",    HEX0, 7'b1000110);

        // Typematic repeats, then break: toggle key keeps its latch.
        for (int i = 0; i < 3; i++) send_frame(8'h1C);
        check("typ_state", key_state[0], 1'b1);
        check("typ_held",  key_held[0], 1'b1);
        send_frame(8'hF0);
        send_frame(8'h1C);
        check("brk_flag",  last_brk, 1'b1);
        check("brk_held",  key_held[0], 1'b0);
        check("brk_state", key_state[0], 1'b1);
        send_frame(8'h1C);
        send_frame(8'hF0);
        send_frame(8'h1C);
        check("a2_held",   key_held[0], 1'b0);
        check("a2_state",  key_state[0], 1'b0);

        // Momentary LShift (index 31).
        send_frame(8'h12);
        check("sh_held",   key_held[31], 1'b1);
        check("sh_state",  key_state[31], 1'b1);
        check("sh_brk0",   last_brk, 1'b0);
        send_frame(8'hF0);
        send_frame(8'h12);
        check("sh_brk1",   last_brk, 1'b1);
        check("sh_held0",  key_held[31], 1'b0);
        check("sh_state0", key_state[31], 1'b0);

        // Extended events leave the bitmaps alone.
        v0 = n_valid;
        send_frame(8'hE0);
        send_frame(8'h14);
        check("e0_code",   last_code, 8'h14);
        check("e0_ext",    last_ext, 1'b1);
        check("e0_brk",    last_brk, 1'b0);
        check("e0_held",   key_held, 33'h0);
        send_frame(8'hE0);
        send_frame(8'hF0);
        send_frame(8'h14);
        check("e0f0_ext",  last_ext, 1'b1);
        check("e0f0_brk",  last_brk, 1'b1);
        check("e0_nvalid", n_valid - v0, 2);
        check("e0_state",  key_state, 33'h0);
        check("e0_held2",  key_held, 33'h0);

        // Parity and stop errors.
        v0 = n_valid; e0 = n_err;
        send_frame(8'h1C, 1'b1, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b1);
        check("err_count",  n_err - e0, 2);
        check("err_nvalid", n_valid - v0, 0);
        check("err_held",   key_held, 33'h0);
        check("err_state",  key_state, 33'h0);
        // A pending F0 is dropped by an errored frame.
        send_frame(8'hF0);
        send_frame(8'h1C, 1'b1, 1'b0);
        send_frame(8'h1C);
        check("errclr_nvalid", n_valid - v0, 1);
        check("errclr_brk",    last_brk, 1'b0);
        check("errclr_held",   key_held[0], 1'b1);

        // Timeout after 4 data bits; pending E0 must also be dropped.
        send_frame(8'hE0);
        e0 = n_err;
        send_partial(11'b11_0101_1010_0, 5);
        first_k = -1;
        for (int k = 1; k <= 2 * T; k++) begin
            @(posedge CLOCK_50);
            @(negedge CLOCK_50);
            if (k == HB) PS2_CLK = 1'b1;
            if (frame_err && first_k < 0) first_k = k;
        end
        #1;
        check("to_latency", first_k, F + 2 + T);
        check("to_count",   n_err - e0, 1);
        PS2_CLK = 1'b1;
        PS2_DAT = 1'b1;
        wait_cycles(HB);
        send_frame(8'h24);
        check("to_next_code", last_code, 8'h24);
        check("to_next_ext",  last_ext, 1'b0);
        check("to_next_held", key_held[4], 1'b1);

        // Short clock glitches are filtered out.
        v0 = n_valid; e0 = n_err;
        PS2_DAT = 1'b0;
        for (int i = 0; i < 5; i++) begin
            PS2_CLK = 1'b0;
            wait_cycles(3);
            PS2_CLK = 1'b1;
            wait_cycles(20);
        end
        PS2_DAT = 1'b1;
        wait_cycles(HB);
        send_frame(8'h2B);
        check("gl_code",   last_code, 8'h2B);
        check("gl_nvalid", n_valid - v0, 1);
        check("gl_nerr",   n_err - e0, 0);

        // Reset mid-frame: silent abort, outputs back at reset values.
        v0 = n_valid; e0 = n_err;
        send_partial(11'b11_0001_1100_0, 4);
        wait_cycles(HB);
        PS2_CLK = 1'b1;
        Resetn  = 1'b0;
        wait_cycles(5);
        Resetn  = 1'b1;
        wait_cycles(2 * T);
        check("mr_nvalid", n_valid - v0, 0);
        check("mr_nerr",   n_err - e0, 0);
        check("mr_code",   scan_code, 8'h00);
        check("mr_held",   key_held, 33'h0);
        check("mr_state",  key_state, 33'h0);
        check("mr_hex0",   HEX0, 7'b1000000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
